mvm_sequencer: RTL

MVM_SEQUENCER -- requirements
Module: mvm_sequencer

---
 rtl/mvm_pkg.sv | 24 ++
 rtl/mvm_skew_gen.sv | 37 +++
 rtl/mvm_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared constants and state encoding for the MVM sequencer
// Build option: MVM_SEQ_SKEW_EN selects skewed row enables (longer EXEC phase).
package mvm_pkg;

    localparam int NUM_ROWS       = 8;
    localparam int NUM_WORDS      = 9;
    localparam int BYTES_PER_WORD = 8;

    // Number of active EXEC steps (k = 0 .. EXEC_LEN-1); one drain step follows.
`ifdef MVM_SEQ_SKEW_EN
    localparam int EXEC_LEN = NUM_ROWS + BYTES_PER_WORD - 1;
`else
    localparam int EXEC_LEN = BYTES_PER_WORD;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GET  = 3'd1,
        ST_FILL = 3'd2,
        ST_EXEC = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mvm_skew_gen.sv
// rtl/mvm_skew_gen.sv - maps EXEC step k to FIFO read and MAC enable strobes
// Ports: i_exec (EXEC state flag), i_k (step index),
//        o_fifo_rd (row FIFOs 0..7 + vector FIFO 8), o_mac_en (per-row MAC enable).
// Build option: MVM_SEQ_SKEW_EN -> row i active for k in i..i+7, else all rows for k in 0..7.
module mvm_skew_gen
    import mvm_pkg::*;
(
    input  logic       i_exec,
    input  logic [3:0] i_k,
    output logic [8:0] o_fifo_rd,
    output logic [7:0] o_mac_en
);

    always_comb begin
        o_fifo_rd = '0;
        o_mac_en  = '0;
        if (i_exec) begin
`ifdef MVM_SEQ_SKEW_EN
            // Vector stream leaves first; row i joins i steps later so its
            // partial products line up with the systolic vector wavefront.
            o_fifo_rd[NUM_ROWS] = (int'(i_k) < BYTES_PER_WORD);
            for (int i = 0; i < NUM_ROWS; i++) begin
                if (int'(i_k) >= i && int'(i_k) < i + BYTES_PER_WORD) begin
                    o_fifo_rd[i] = 1'b1;
                    o_mac_en[i]  = 1'b1;
                end
            end
`else
            if (int'(i_k) < BYTES_PER_WORD) begin
                o_fifo_rd = '1;
                o_mac_en  = '1;
            end
`endif
        end
    end

endmodule

// File: rtl/mvm_sequencer.sv
// rtl/mvm_sequencer.sv - loads 8 matrix rows + 1 vector from memory into FIFOs, then runs the MAC array
// Ports: clk, rst (sync active-high); start / acc_clr / busy / done / state (control);
//        mem_rd, mem_addr, mem_waitrequest, mem_rdvalid, mem_rddata (word read port);
//        fifo_wr, fifo_wdata, fifo_full (FIFO fill side); fifo_rd, mac_en (execute side).
// Build option: MVM_SEQ_SKEW_EN enables skewed EXEC strobes (see mvm_skew_gen).
module mvm_sequencer
    import mvm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        acc_clr,
    output logic        mem_rd,
    output logic [3:0]  mem_addr,
    input  logic        mem_waitrequest,
    input  logic        mem_rdvalid,
    input  logic [63:0] mem_rddata,
    output logic [8:0]  fifo_wr,
    output logic [7:0]  fifo_wdata,
    input  logic [8:0]  fifo_full,
    output logic [8:0]  fifo_rd,
    output logic [7:0]  mac_en,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state
);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_w, w_w_nxt;
    logic [2:0]  r_b, w_b_nxt;
    logic [3:0]  r_k, w_k_nxt;
    logic        r_accepted, w_accepted_nxt;
    logic [63:0] r_word, w_word_nxt;
    logic        r_acc_clr, w_acc_clr_nxt;
    logic        w_exec;
    logic        w_full;
    logic [7:0]  w_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_w        <= '0;
            r_b        <= '0;
            r_k        <= '0;
            r_accepted <= 1'b0;
            r_word     <= '0;
            r_acc_clr  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_w        <= w_w_nxt;
            r_b        <= w_b_nxt;
            r_k        <= w_k_nxt;
            r_accepted <= w_accepted_nxt;
            r_word     <= w_word_nxt;
            r_acc_clr  <= w_acc_clr_nxt;
        end
    end

    // Byte b of the captured word, most significant byte first.
    assign w_byte = 8'(r_word >> {(3'd7 - r_b), 3'b000});
    assign w_full = fifo_full[r_w];

    always_comb begin
        w_state_nxt    = r_state;
        w_w_nxt        = r_w;
        w_b_nxt        = r_b;
        w_k_nxt        = r_k;
        w_accepted_nxt = r_accepted;
        w_word_nxt     = r_word;
        w_acc_clr_nxt  = 1'b0;
        mem_rd         = 1'b0;
        mem_addr       = '0;
        fifo_wr        = '0;
        fifo_wdata     = '0;
        done           = 1'b0;
        w_exec         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt    = ST_GET;
                    w_w_nxt        = '0;
                    w_b_nxt        = '0;
                    w_k_nxt        = '0;
                    w_accepted_nxt = 1'b0;
                    w_acc_clr_nxt  = 1'b1;
                end
            end

            ST_GET: begin
                // Hold the request until accepted, then only listen for data;
                // rdvalid before acceptance belongs to no request of ours.
                if (!r_accepted) begin
                    mem_rd   = 1'b1;
                    mem_addr = r_w;
                    if (!mem_waitrequest) begin
                        w_accepted_nxt = 1'b1;
                    end
                end else if (mem_rdvalid) begin
                    w_word_nxt     = mem_rddata;
                    w_accepted_nxt = 1'b0;
                    w_b_nxt        = '0;
                    w_state_nxt    = ST_FILL;
                end
            end

            ST_FILL: begin
                if (!w_full) begin
                    fifo_wr[r_w] = 1'b1;
                    fifo_wdata   = w_byte;
                    if (r_b == 3'd7) begin
                        w_b_nxt = '0;
                        if (r_w == 4'(NUM_WORDS - 1)) begin
                            w_k_nxt     = '0;
                            w_state_nxt = ST_EXEC;
                        end else begin
                            w_w_nxt     = r_w + 4'd1;
                            w_state_nxt = ST_GET;
                        end
                    end else begin
                        w_b_nxt = r_b + 3'd1;
                    end
                end
            end

            ST_EXEC: begin
                // k == EXEC_LEN is the drain step: skew_gen yields no strobes there.
                w_exec = 1'b1;
                if (r_k == 4'(EXEC_LEN)) begin
                    w_k_nxt     = '0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_k_nxt = r_k + 4'd1;
                end
            end

            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    mvm_skew_gen u_skew_gen (
        .i_exec    (w_exec),
        .i_k       (r_k),
        .o_fifo_rd (fifo_rd),
        .o_mac_en  (mac_en)
    );

    assign acc_clr = r_acc_clr;
    assign busy    = (r_state != ST_IDLE);
    assign state   = r_state;

endmodule
